// File: rtl/b9_resp_misr.sv
// ---------------------------------------------------------------------------
// b9_resp_misr
//   Response-compaction stage placed after the combinational b9 core. Beats
//   of the 21-bit b9 output vector are folded into a multiple-input signature
//   register (MISR) over a programmed number of beats. The final signature is
//   then compared against an expected value.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   begin a run (honoured only in IDLE)
//   num_beats  in   CW  beats to compact, sampled with start
//   exp_sig    in   W   expected signature, sampled with start
//   resp_valid in   resp_data carries a beat
//   resp_data  in   W   b9 response {a1..j1,p0..z0}, a1 = MSB
//   resp_ready out  a beat is accepted this cycle when resp_valid is high
//   busy       out  run in progress
//   done       out  result available; sig/pass are valid
//   done_ack   in   consumer releases the result
//   sig        out  W   current signature register
//   pass       out  sig matches the latched expected signature (while done)
//   beat_cnt   out  CW  beats accepted in the current run
// ---------------------------------------------------------------------------
module b9_resp_misr #(
  parameter int unsigned    W    = 21,
  parameter int unsigned    CW   = 16,
  parameter logic [W-1:0]   POLY = 21'h000005,
  parameter logic [W-1:0]   SEED = 21'h000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_beats,
  input  logic [W-1:0]  exp_sig,
  input  logic          resp_valid,
  input  logic [W-1:0]  resp_data,
  output logic          resp_ready,
  output logic          busy,
  output logic          done,
  input  logic          done_ack,
  output logic [W-1:0]  sig,
  output logic          pass,
  output logic [CW-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sig_q,   sig_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [CW-1:0] n_q,     n_d;
  logic [W-1:0]  e_q,     e_d;

  // One MISR step: shift left, fold the bit shifted out of the MSB back in
  // through the feedback taps, then XOR in the incoming response beat.
  function automatic logic [W-1:0] misr_step(input logic [W-1:0] s,
                                             input logic [W-1:0] d);
    logic [W-1:0] fb;
    fb = s[W-1] ? POLY : '0;
    return {s[W-2:0], 1'b0} ^ fb ^ d;
  endfunction

  logic accept;
  assign accept = (state_q == ST_RUN) && resp_valid;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    e_d     = e_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = num_beats;
          e_d     = exp_sig;
          sig_d   = SEED;
          cnt_d   = '0;
          // An empty run goes straight to DONE so pass reflects SEED == E.
          state_d = (num_beats != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (accept) begin
          sig_d = misr_step(sig_q, resp_data);
          cnt_d = cnt_q + CW'(1);
          // n_q is non-zero in RUN, so n_q-1 never underflows.
          if (cnt_q == n_q - CW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // start together with done_ack is deliberately ignored.
        if (done_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      n_q     <= '0;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      e_q     <= e_d;
    end
  end

  // All outputs decode from registered state only.
  assign resp_ready = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = (state_q == ST_DONE) && (sig_q == e_q);
  assign sig        = sig_q;
  assign beat_cnt   = cnt_q;

endmodule
